fxp_serial_sub: RTL and testbench
=================================

Name: fxp_serial_sub

Overview:
- Sequential bit-serial subtractor for signed fixed-point Q7.8 words: computes Out = A - B, one bit per clock, LSB first.
- Sits in the Execution stage beside the combinational fixed-point adder and serves the subtract operation (op=1) that the adder does not cover.
- Produces the same N/V/Z flag set as the adder, so the flag-writeback path is shared.
- Trades 16-cycle latency for a single-bit datapath (one full-subtractor plus borrow flop).

Parameters:
- DATA_WIDTH, 16, total word width in bits; integer part is the upper DATA_WIDTH/2 bits, fraction the lower DATA_WIDTH/2 (Q7.8 at default).
- CNT_W, $clog2(DATA_WIDTH), width of the bit-position counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request pulse; operands sampled on the edge where start=1 and the block is not busy.
- A  input  DATA_WIDTH  minuend, signed two's complement fixed point.
- B  input  DATA_WIDTH  subtrahend, signed two's complement fixed point.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse; Out and flags are valid from this cycle onward.
- Out  output  DATA_WIDTH  registered result; holds its value until the next accepted start.
- N  output  1  Out[DATA_WIDTH-1] of the final result.
- V  output  1  signed overflow of A - B detected.
- Z  output  1  high when the final Out == 0.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, Out=0, N=0, V=0, Z=0; counter=0 and borrow=0. Reset wins over every other input, including mid-operation; an aborted operation produces no done.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on start=1, latch A and B into shift registers, clear borrow, set counter=0, go to SHIFT; busy=1 from the next cycle.
- SHIFT: once per edge, process bit i=counter:
  - d = a_i ^ b_i ^ borrow
  - borrow' = (~a_i & b_i) | (~a_i & borrow) | (b_i & borrow)
  - shift d into the result register MSB-side; increment counter.
  - On the edge that processes i=DATA_WIDTH-1: compute V = (A_sign != B_sign) && (raw_sign != A_sign); write Out, N, Z from the final value; go to DONE with busy=0 and done=1.
- DONE: lasts exactly one cycle, then IDLE.
  - start=1 in DONE is accepted exactly as in IDLE, giving back-to-back operation with no gap cycle.
- Latency: start sampled at edge k; result, flags and done visible after edge k+16. Throughput is one result per 17 cycles.
- start while busy=1 is ignored; latched operands are unaffected and no request is queued.
- A and B may change freely after the accepting edge.
- Out, N, V and Z update only on the final SHIFT edge and never show partial results.
- Counter range is 0..DATA_WIDTH-1; no wrap is observable outside SHIFT.
- Arithmetic is exact two's complement over the full word. The fraction borrow propagates into the integer part automatically, so there is no split integer/fraction handling.

Optional Feature:
- Macro: FXP_SUB_SAT_EN.
- Defined: when V=1, Out saturates to the full-word extreme: 0x7FFF if A is non-negative, 0x8000 if A is negative. N and Z are derived from the saturated value.
- Undefined: Out is the wrapped two's-complement result. V is still reported, and N and Z are derived from the wrapped value.

Test Plan:
- A=0x0300 (3.0), B=0x0180 (1.5), start at edge 0 -> done exactly after edge 16, Out=0x0180, N=0, V=0, Z=0; busy high for 16 cycles.
- A=0x0080 (0.5), B=0x0200 (2.0) -> Out=0xFE80 (-1.5), N=1, V=0, Z=0. Then A=B=0x1234 -> Out=0x0000, Z=1, N=0.
- A=0x7F00, B=0xFF00 (127-(-1)) -> V=1; with FXP_SUB_SAT_EN Out=0x7FFF, N=0; without it Out=0x8000, N=1.
- A=0x8000, B=0x0100 (-128-1) -> V=1; with FXP_SUB_SAT_EN Out=0x8000, N=1; without it Out=0x7F00, N=0.
- Start op1, pulse start with different operands at cycle 5 -> ignored, op1 result correct. Start op2 in the DONE cycle of op1 -> op2 done exactly 17 cycles after op1's done.
- Start op, assert rst_n=0 at cycle 8 -> next cycle busy=0, done=0, Out=0, all flags 0; no done pulse follows. A new start after reset completes normally.

Source files
------------

// File: rtl/fxp_serial_sub_if.sv
// fxp_serial_sub_if: request/result bundle for the bit-serial Q7.8 subtractor
//   start, A, B   : request pulse and operands (driven by master)
//   busy, done    : progress status (driven by slave)
//   Out, N, V, Z  : registered result and flags (driven by slave)
interface fxp_serial_sub_if #(parameter int DATA_WIDTH = 16) ();
    logic                  start;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] Out;
    logic                  N;
    logic                  V;
    logic                  Z;
    modport master (output start, A, B, input busy, done, Out, N, V, Z);
    modport slave  (input start, A, B, output busy, done, Out, N, V, Z);
endinterface

// File: rtl/fxp_serial_sub.sv
// fxp_serial_sub: bit-serial signed fixed-point subtractor, Out = A - B, LSB first
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : fxp_serial_sub_if.slave (start/A/B in, busy/done/Out/N/V/Z out)
//   FXP_SUB_SAT_EN : when defined, overflowing results saturate to the word extreme
module fxp_serial_sub #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input logic             clk,
    input logic             rst_n,
    fxp_serial_sub_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] a_sr, b_sr;
    logic [DATA_WIDTH-2:0] res_sr;
    logic [CNT_W-1:0]      cnt;
    logic                  borrow, borrow_n, d, load, last, v_n;
    logic [DATA_WIDTH-1:0] raw, fin, out_q;
    logic                  n_q, v_q, z_q;

    always_comb begin
        load     = bus.start && state != SHIFT;
        last     = state == SHIFT && cnt == CNT_W'(DATA_WIDTH-1);
        d        = a_sr[0] ^ b_sr[0] ^ borrow;
        borrow_n = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & borrow) | (b_sr[0] & borrow);
        // on the last step a_sr[0]/b_sr[0] are the operand sign bits and d is the raw sign
        raw      = {d, res_sr};
        v_n      = (a_sr[0] != b_sr[0]) && (d != a_sr[0]);
`ifdef FXP_SUB_SAT_EN
        fin      = v_n ? (a_sr[0] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}}) : raw;
`else
        fin      = raw;
`endif
        state_n  = load ? SHIFT : last ? DONE : state == DONE ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            out_q  <= '0;
            n_q    <= 1'b0;
            v_q    <= 1'b0;
            z_q    <= 1'b0;
        end else if (load) begin
            a_sr   <= bus.A;
            b_sr   <= bus.B;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {d, res_sr[DATA_WIDTH-2:1]};
            borrow <= borrow_n;
            cnt    <= cnt + 1'b1;
            if (last) begin
                out_q <= fin;
                n_q   <= fin[DATA_WIDTH-1];
                v_q   <= v_n;
                z_q   <= fin == '0;
            end
        end
    end

    assign bus.busy = state == SHIFT;
    assign bus.done = state == DONE;
    assign bus.Out  = out_q;
    assign bus.N    = n_q;
    assign bus.V    = v_q;
    assign bus.Z    = z_q;
endmodule

// File: tb/tb_fxp_serial_sub.sv
// tb_fxp_serial_sub: self-checking bench for fxp_serial_sub against an arithmetic model
module tb_fxp_serial_sub;
    logic clk, rst_n;
    int   compared, mismatched;
    fxp_serial_sub_if #(.DATA_WIDTH(16)) bus ();
    fxp_serial_sub #(.DATA_WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {Out, N, V, Z} from plain integer subtraction
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b);
        int          diff;
        logic        v;
        logic [15:0] w;
        diff = int'($signed(a)) - int'($signed(b));
        v    = diff > 32767 || diff < -32768;
        w    = diff[15:0];
`ifdef FXP_SUB_SAT_EN
        if (v) w = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {w, w[15], v, w == 16'h0000};
    endfunction

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A = 16'($urandom);
        bus.B = 16'($urandom);
    endtask

    // waits for done, re-pulsing start at cycle ign (ign<0: never); checks latency and results
    task automatic finish_op(input string tag, input logic [15:0] a, input logic [15:0] b, input int ign);
        int          cyc, busy_cnt;
        logic [18:0] e;
        cyc = 0;
        busy_cnt = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) busy_cnt++;
            if (cyc == ign) begin
                bus.start = 1'b1;
                bus.A = 16'($urandom);
                bus.B = 16'($urandom);
            end
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end
        e = model(a, b);
        check({tag, ".latency"}, cyc, 16);
        check({tag, ".busy_cycles"}, busy_cnt, 16);
        check({tag, ".done"}, bus.done, 1);
        check({tag, ".busy_at_done"}, bus.busy, 0);
        check({tag, ".out"}, bus.Out, e[18:3]);
        check({tag, ".nvz"}, {bus.N, bus.V, bus.Z}, e[2:0]);
    endtask

    task automatic full_op(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [18:0] e;
        start_op(a, b);
        finish_op(tag, a, b, -1);
        e = model(a, b);
        @(negedge clk);
        check({tag, ".done_pulse"}, bus.done, 0);
        check({tag, ".out_hold"}, bus.Out, e[18:3]);
    endtask

    initial begin
        int          dones;
        logic [15:0] ra, rb;
        compared = 0;
        mismatched = 0;
        bus.start = 1'b0;
        bus.A = 16'h0;
        bus.B = 16'h0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.busy", bus.busy, 0);
        check("reset.done", bus.done, 0);
        check("reset.out", bus.Out, 0);
        check("reset.nvz", {bus.N, bus.V, bus.Z}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        full_op("sub_3_1p5", 16'h0300, 16'h0180);
        check("sub_3_1p5.value", bus.Out, 16'h0180);
        full_op("sub_neg", 16'h0080, 16'h0200);
        check("sub_neg.value", bus.Out, 16'hFE80);
        full_op("sub_zero", 16'h1234, 16'h1234);
        check("sub_zero.z", bus.Z, 1);
        full_op("ovf_pos", 16'h7F00, 16'hFF00);
        check("ovf_pos.v", bus.V, 1);
        full_op("ovf_neg", 16'h8000, 16'h0100);
        check("ovf_neg.v", bus.V, 1);
        full_op("ovf_edge", 16'h8000, 16'h8000);
        full_op("ovf_max", 16'h7FFF, 16'h8000);

        start_op(16'h0500, 16'h0123);
        finish_op("ignored", 16'h0500, 16'h0123, 5);
        start_op(16'h4000, 16'hC000);
        finish_op("b2b", 16'h4000, 16'hC000, -1);
        @(negedge clk);

        start_op(16'h2222, 16'h1111);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort.busy", bus.busy, 0);
        check("abort.done", bus.done, 0);
        check("abort.out", bus.Out, 0);
        check("abort.nvz", {bus.N, bus.V, bus.Z}, 0);
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort.no_done", dones, 0);
        full_op("after_reset", 16'h0A00, 16'h0300);

        repeat (20) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            full_op("random", ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
